// File: rtl/vga_sync_phase_generator.sv
// Turns the zero/threshold pulses of the VGA horizontal and vertical counters into sync, blanking
// and line-advance strobes. The front porch and sync widths are timed here; the back porch ends on counter wrap.
//
// state     | meaning
// ST_ACTIVE | visible region, waiting for the end-of-visible threshold
// ST_FRONT  | front porch, phase counts porch ticks
// ST_SYNC   | sync pulse asserted, phase counts sync ticks
// ST_BACK   | back porch, held until the counter wraps to zero
module vga_sync_phase_generator #(
  parameter int   H_FRONT_PORCH  = 16,
  parameter int   H_SYNC_WIDTH   = 96,
  parameter int   V_FRONT_PORCH  = 10,
  parameter int   V_SYNC_WIDTH   = 2,
  parameter logic HSYNC_POLARITY = 1'b0,
  parameter logic VSYNC_POLARITY = 1'b0,
  parameter int   PHASE_SIZE     = 8
) (
  input  logic control_clock,
  input  logic control_reset_n,
  input  logic pixel_enable,
  input  logic h_zero_detected,
  input  logic h_threshold_detected,
  input  logic v_zero_detected,
  input  logic v_threshold_detected,
  output logic hsync,
  output logic vsync,
  output logic video_on,
  output logic v_counter_enable,
  output logic frame_start,
  output logic sync_error
);

  typedef enum logic [1:0] {ST_ACTIVE, ST_FRONT, ST_SYNC, ST_BACK} phase_state_t;

  typedef struct packed {
    phase_state_t          state;
    logic [PHASE_SIZE-1:0] phase;
    logic                  wrap;
    logic                  resync;
  } axis_t;

  localparam logic [PHASE_SIZE-1:0] H_FP_LAST   = PHASE_SIZE'(H_FRONT_PORCH - 1);
  localparam logic [PHASE_SIZE-1:0] H_SYNC_LAST = PHASE_SIZE'(H_SYNC_WIDTH - 1);
  localparam logic [PHASE_SIZE-1:0] V_FP_LAST   = PHASE_SIZE'(V_FRONT_PORCH - 1);
  localparam logic [PHASE_SIZE-1:0] V_SYNC_LAST = PHASE_SIZE'(V_SYNC_WIDTH - 1);

  phase_state_t          h_state, v_state;
  logic [PHASE_SIZE-1:0] h_phase, v_phase;
  logic                  line_tick;
  axis_t                 h_nx, v_nx;

  // Shared transition rule for both axes; a zero outside BACK forces a resync instead of a wrap.
  function automatic axis_t step(input logic                  en,
                                 input phase_state_t          st,
                                 input logic [PHASE_SIZE-1:0] ph,
                                 input logic                  zero,
                                 input logic                  thr,
                                 input logic [PHASE_SIZE-1:0] fp_last,
                                 input logic [PHASE_SIZE-1:0] sync_last);
    axis_t r;
    r.state  = st;
    r.phase  = ph;
    r.wrap   = 1'b0;
    r.resync = 1'b0;
    if (en) begin
      if (zero) begin
        r.state  = ST_ACTIVE;
        r.phase  = '0;
        r.wrap   = (st == ST_BACK);
        r.resync = (st != ST_BACK);
      end else begin
        case (st)
          ST_ACTIVE: if (thr) begin
            r.state = ST_FRONT;
            r.phase = '0;
          end
          ST_FRONT: if (ph == fp_last) begin
            r.state = ST_SYNC;
            r.phase = '0;
          end else r.phase = ph + 1'b1;
          ST_SYNC: if (ph == sync_last) begin
            r.state = ST_BACK;
            r.phase = '0;
          end else r.phase = ph + 1'b1;
          default: ;
        endcase
      end
    end
    return r;
  endfunction

  always_comb begin
    h_nx = step(pixel_enable, h_state, h_phase, h_zero_detected, h_threshold_detected,
                H_FP_LAST, H_SYNC_LAST);
    v_nx = step(line_tick, v_state, v_phase, v_zero_detected, v_threshold_detected,
                V_FP_LAST, V_SYNC_LAST);
  end

  always_ff @(posedge control_clock or negedge control_reset_n) begin
    if (!control_reset_n) begin
      h_state          <= ST_BACK;
      h_phase          <= '0;
      v_state          <= ST_ACTIVE;
      v_phase          <= '0;
      line_tick        <= 1'b0;
      hsync            <= ~HSYNC_POLARITY;
      vsync            <= ~VSYNC_POLARITY;
      video_on         <= 1'b0;
      v_counter_enable <= 1'b0;
      frame_start      <= 1'b0;
      sync_error       <= 1'b0;
    end else begin
      h_state          <= h_nx.state;
      h_phase          <= h_nx.phase;
      v_state          <= v_nx.state;
      v_phase          <= v_nx.phase;
      // The vertical counter advances on v_counter_enable, so its detects settle one cycle later.
      line_tick        <= v_counter_enable;
      v_counter_enable <= h_nx.wrap;
      frame_start      <= v_nx.wrap;
      sync_error       <= sync_error | h_nx.resync | v_nx.resync;
      hsync            <= (h_nx.state == ST_SYNC) ? HSYNC_POLARITY : ~HSYNC_POLARITY;
      vsync            <= (v_nx.state == ST_SYNC) ? VSYNC_POLARITY : ~VSYNC_POLARITY;
      video_on         <= (h_nx.state == ST_ACTIVE) && (v_nx.state == ST_ACTIVE);
    end
  end

endmodule
